// File: rtl/clause_table_pkg.sv
// Shared definitions for the multi-port clause table: width helpers,
// FSM state encoding and lane slicing helpers.
package clause_table_pkg;

    // Operating modes of the table.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Packed width of one row: each clause carries NSAT-1 literals of
    // (address + polarity) bits.
    function automatic int ct_width(input int var_addr_w, input int nsat, input int clause_count);
        return (var_addr_w + 1) * (nsat - 1) * clause_count;
    endfunction

    // Row address width.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Low bit of lane 'lane' in a flat vector of 'w'-bit lanes.
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/clause_table_bank.sv
// One bank of the clause table: a DEPTH x WIDTH RAM with one write port
// and one synchronous read port. The read register holds its value when
// no read is issued and resets to zero.
module clause_table_bank #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 480,
    parameter int AW    = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array write; no reset so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Read register returns the pre-write contents on a same-row collision;
    // the top level patches that case with its forwarding path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   rdata_o <= '0;
        else if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/clause_table_mp.sv
// Multi-port clause table: replicated banks share one write port, each
// lane reads its own bank. A sweep FSM zeroes the table after reset or on
// request, AXI writes are only accepted while loading, and same-cycle
// write/read collisions return the new data.
module clause_table_mp
    import clause_table_pkg::*;
#(
    parameter  int CLAUSE_COUNT           = 20,
    parameter  int DEPTH                  = 2048,
    parameter  int VARIABLE_ADDRESS_WIDTH = 11,
    parameter  int NSAT                   = 3,
    parameter  int NUM_RD_PORTS           = 2,
    parameter  int OUT_REG                = 0,
    localparam int CT_WIDTH = ct_width(VARIABLE_ADDRESS_WIDTH, NSAT, CLAUSE_COUNT),
    localparam int AW       = addr_width(DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             run_i,
    input  logic                             axi_wr_en_i,
    input  logic [AW-1:0]                    axi_wr_addr_i,
    input  logic [CT_WIDTH-1:0]              axi_wr_clauses_i,
    output logic                             axi_wr_ready_o,
    output logic                             axi_wr_err_o,
    input  logic [NUM_RD_PORTS-1:0]          rd_valid_i,
    input  logic [NUM_RD_PORTS*AW-1:0]       rd_addr_i,
    output logic                             rd_ready_o,
    output logic [NUM_RD_PORTS*CT_WIDTH-1:0] clauses_o,
    output logic [NUM_RD_PORTS-1:0]          clauses_valid_o,
    output logic                             busy_o
);

    localparam int              STAGES   = 1 + OUT_REG;
    localparam logic [AW-1:0]   LAST_ROW = AW'(DEPTH - 1);

    state_t                                    state;
    logic [AW-1:0]                             cnt;
    logic                                      wr_acc;
    logic                                      mem_we;
    logic [AW-1:0]                             mem_waddr;
    logic [CT_WIDTH-1:0]                       mem_wdata;
    logic [NUM_RD_PORTS-1:0]                   rd_acc;
    logic [NUM_RD_PORTS-1:0][AW-1:0]           lane_addr;
    logic [NUM_RD_PORTS-1:0][CT_WIDTH-1:0]     bank_rdata;
    logic [NUM_RD_PORTS-1:0][CT_WIDTH-1:0]     lane_s1;
    logic [NUM_RD_PORTS-1:0][CT_WIDTH-1:0]     lane_out;
    logic [STAGES:1][NUM_RD_PORTS-1:0]         vld_pipe;

    // Clear wins over a coincident AXI write; RUN and CLEAR reject writes.
    assign wr_acc    = (state == ST_LOAD) && axi_wr_en_i && !clear_i;
    assign mem_we    = (state == ST_CLEAR) || wr_acc;
    assign mem_waddr = (state == ST_CLEAR) ? cnt : axi_wr_addr_i;
    assign mem_wdata = (state == ST_CLEAR) ? '0  : axi_wr_clauses_i;
    assign rd_acc    = rd_valid_i & {NUM_RD_PORTS{rd_ready_o}};

    // Mode FSM with sweep counter; ready/busy flags are registered alongside
    // the state so they change on the same edge as the mode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_CLEAR;
            cnt            <= '0;
            busy_o         <= 1'b1;
            axi_wr_ready_o <= 1'b0;
            rd_ready_o     <= 1'b0;
            axi_wr_err_o   <= 1'b0;
        end else begin
            axi_wr_err_o <= axi_wr_en_i && !wr_acc;
            case (state)
                ST_CLEAR: begin
                    if (cnt == LAST_ROW) begin
                        state          <= ST_LOAD;
                        cnt            <= '0;
                        busy_o         <= 1'b0;
                        axi_wr_ready_o <= 1'b1;
                        rd_ready_o     <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                ST_LOAD: begin
                    if (clear_i) begin
                        state          <= ST_CLEAR;
                        cnt            <= '0;
                        busy_o         <= 1'b1;
                        axi_wr_ready_o <= 1'b0;
                        rd_ready_o     <= 1'b0;
                    end else if (run_i) begin
                        state          <= ST_RUN;
                        axi_wr_ready_o <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!run_i) begin
                        state          <= ST_LOAD;
                        axi_wr_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state          <= ST_CLEAR;
                    cnt            <= '0;
                    busy_o         <= 1'b1;
                    axi_wr_ready_o <= 1'b0;
                    rd_ready_o     <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane valid shift register; last stage drives clauses_valid_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_lane
        logic                fwd_q;
        logic [CT_WIDTH-1:0] fwd_data_q;
        logic                hit;

        assign lane_addr[g] = rd_addr_i[lane_lo(g, AW) +: AW];
        assign hit          = wr_acc && (axi_wr_addr_i == lane_addr[g]);

        clause_table_bank #(
            .DEPTH (DEPTH),
            .WIDTH (CT_WIDTH),
            .AW    (AW)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (mem_we),
            .waddr_i (mem_waddr),
            .wdata_i (mem_wdata),
            .re_i    (rd_acc[g]),
            .raddr_i (lane_addr[g]),
            .rdata_o (bank_rdata[g])
        );

        // Remember a write-first collision; only updated on an accepted read
        // so an idle lane keeps presenting its last result.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fwd_q      <= 1'b0;
                fwd_data_q <= '0;
            end else if (rd_acc[g]) begin
                fwd_q <= hit;
                if (hit) fwd_data_q <= axi_wr_clauses_i;
            end
        end

        assign lane_s1[g] = fwd_q ? fwd_data_q : bank_rdata[g];
        assign clauses_o[lane_lo(g, CT_WIDTH) +: CT_WIDTH] = lane_out[g];
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [NUM_RD_PORTS-1:0][CT_WIDTH-1:0] out_q;

        // Optional output stage; captures only lanes carrying valid data.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_q <= '0;
            end else begin
                for (int l = 0; l < NUM_RD_PORTS; l++)
                    if (vld_pipe[1][l]) out_q[l] <= lane_s1[l];
            end
        end

        assign lane_out = out_q;
    end else begin : g_noreg
        assign lane_out = lane_s1;
    end

    assign clauses_valid_o = vld_pipe[STAGES];

endmodule

// File: tb/tb_clause_table_mp.sv
// Scoreboard bench for clause_table_mp: two instances (OUT_REG=0 and 1)
// share stimulus; expected read data and arrival cycle are queued at issue
// and checked by a monitor on the falling edge.
module tb_clause_table_mp;

    localparam int W  = 20;
    localparam int AW = 4;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            run = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [W-1:0]    wr_data = '0;
    logic [1:0]      rd_valid = '0;
    logic [2*AW-1:0] rd_addr = '0;

    logic            wr_ready0, wr_ready1, err0, err1, rd_ready0, rd_ready1, busy0, busy1;
    logic [2*W-1:0]  cl0, cl1;
    logic [1:0]      cv0, cv1;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clause_table_mp #(.CLAUSE_COUNT(2), .DEPTH(16), .VARIABLE_ADDRESS_WIDTH(4), .NSAT(3),
                      .NUM_RD_PORTS(2), .OUT_REG(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .run_i(run),
        .axi_wr_en_i(wr_en), .axi_wr_addr_i(wr_addr), .axi_wr_clauses_i(wr_data),
        .axi_wr_ready_o(wr_ready0), .axi_wr_err_o(err0),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready0),
        .clauses_o(cl0), .clauses_valid_o(cv0), .busy_o(busy0));

    clause_table_mp #(.CLAUSE_COUNT(2), .DEPTH(16), .VARIABLE_ADDRESS_WIDTH(4), .NSAT(3),
                      .NUM_RD_PORTS(2), .OUT_REG(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .run_i(run),
        .axi_wr_en_i(wr_en), .axi_wr_addr_i(wr_addr), .axi_wr_clauses_i(wr_data),
        .axi_wr_ready_o(wr_ready1), .axi_wr_err_o(err1),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready1),
        .clauses_o(cl1), .clauses_valid_o(cv1), .busy_o(busy1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pop and compare every valid lane of one instance.
    task automatic mon(input int d, input logic [1:0] v, input logic [2*W-1:0] c);
        exp_t e;
        for (int l = 0; l < 2; l++) begin
            if (v[l]) begin
                if (sb[d*2+l].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid dut%0d lane%0d: got %0h expected none", d, l, c[l*W +: W]);
                end else begin
                    e = sb[d*2+l].pop_front();
                    chk($sformatf("rd_data dut%0d lane%0d", d, l), c[l*W +: W], e.data);
                    chk($sformatf("rd_latency dut%0d lane%0d", d, l), cyc, e.due);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, cv0, cl0);
            mon(1, cv1, cl1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        clear    = 1'b0;
        rd_valid = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    // Present a read; expectations are queued with per-instance latency.
    task automatic rd(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [W-1:0] e0, input logic [W-1:0] e1);
        rd_valid = v;
        rd_addr  = {a1, a0};
        if (v[0]) begin
            sb[0].push_back('{e0, cyc + 1});
            sb[2].push_back('{e0, cyc + 2});
        end
        if (v[1]) begin
            sb[1].push_back('{e1, cyc + 1});
            sb[3].push_back('{e1, cyc + 2});
        end
    endtask

    task automatic drain();
        repeat (3) step();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " clauses0"}, cl0, 0);
        chk({tag, " clauses1"}, cl1, 0);
        chk({tag, " valid"}, {cv1, cv0}, 0);
        chk({tag, " wr_ready"}, {wr_ready1, wr_ready0}, 0);
        chk({tag, " rd_ready"}, {rd_ready1, rd_ready0}, 0);
        chk({tag, " err"}, {err1, err0}, 0);
        chk({tag, " busy"}, {busy1, busy0}, 2'b11);
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (busy0 && n < 40) begin
            step();
            n++;
            if (busy1 !== busy0) chk({name, " busy_match"}, busy1, busy0);
        end
        chk({name, " busy_cycles"}, n, 16);
        chk({name, " rd_ready"}, {rd_ready1, rd_ready0}, 2'b11);
        chk({name, " wr_ready"}, {wr_ready1, wr_ready0}, 2'b11);
    endtask

    initial begin
        repeat (3) step();
        chk_reset("reset");

        // 1: sweep after reset, then rows 0/15 read as zero
        rst_n = 1'b1;
        count_busy("sweep1");
        rd(2'b11, 4'd0, 4'd15, 20'h0, 20'h0);
        step();
        rd(2'b11, 4'd15, 4'd0, 20'h0, 20'h0);
        step();
        idle();
        drain();

        // 2: write row 5, read rows 5/4 together
        wr(4'd5, 20'hABCDE);
        step();
        idle();
        chk("load_err", {err1, err0}, 0);
        rd(2'b11, 4'd5, 4'd4, 20'hABCDE, 20'h0);
        step();
        idle();
        drain();
        chk("hold lane0", cl0[W-1:0], 20'hABCDE);
        chk("hold lane0 oreg", cl1[W-1:0], 20'hABCDE);

        // 3: same-cycle write and read of row 7 forwards the new data
        wr(4'd7, 20'h12345);
        rd(2'b11, 4'd5, 4'd7, 20'hABCDE, 20'h12345);
        step();
        idle();
        rd(2'b01, 4'd7, 4'd0, 20'h12345, 20'h0);
        step();
        idle();
        drain();

        // 4: write in the cycle run rises is accepted, then writes rejected
        run = 1'b1;
        wr(4'd9, 20'h99999);
        step();
        idle();
        chk("run_entry_err", {err1, err0}, 0);
        chk("run_wr_ready", {wr_ready1, wr_ready0}, 0);
        wr(4'd5, 20'h11111);
        step();
        idle();
        chk("run_err_pulse", {err1, err0}, 2'b11);
        step();
        chk("run_err_drop", {err1, err0}, 0);
        rd(2'b11, 4'd5, 4'd9, 20'hABCDE, 20'h99999);
        step();
        idle();
        drain();
        run = 1'b0;
        step();
        chk("load_wr_ready", {wr_ready1, wr_ready0}, 2'b11);
        wr(4'd5, 20'h55555);
        step();
        idle();
        chk("load_wr_err", {err1, err0}, 0);
        rd(2'b01, 4'd5, 4'd0, 20'h55555, 20'h0);
        step();
        idle();
        drain();

        // 5: clear wins over a coincident write, then table reads zero
        clear = 1'b1;
        wr(4'd3, 20'h33333);
        step();
        idle();
        chk("clear_err", {err1, err0}, 2'b11);
        chk("clear_busy", {busy1, busy0}, 2'b11);
        count_busy("sweep2");
        rd(2'b11, 4'd5, 4'd7, 20'h0, 20'h0);
        step();
        rd(2'b11, 4'd9, 4'd3, 20'h0, 20'h0);
        step();
        idle();
        drain();

        // 6: reset mid-sweep returns outputs to reset values at once
        wr(4'd2, 20'h22222);
        step();
        idle();
        rd(2'b11, 4'd2, 4'd2, 20'h22222, 20'h22222);
        step();
        idle();
        drain();
        clear = 1'b1;
        step();
        idle();
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        chk_reset("mid_reset");
        step();
        rst_n = 1'b1;
        count_busy("sweep3");
        rd(2'b11, 4'd2, 4'd5, 20'h0, 20'h0);
        step();
        idle();
        drain();

        chk("sb_empty", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clause_table_mp.md
# clause_table_mp

Multi-port successor to the single-port clause table. It holds the packed clause rows indexed by the address translation table. Up to NUM_RD_PORTS clause evaluator lanes can fetch rows concurrently with valid-qualified, fixed-latency reads. The block adds:
- a hardware clear sequencer, replacing simulation-only memory initialisation;
- LOAD/RUN write locking;
- write-to-read forwarding;
- an optional output register stage.

It sits between the AXI loader and the clause evaluators.

## Interface
- CLAUSE_COUNT, 20, clauses packed per row
- DEPTH, 2048, rows (power of two, ≥ 2)
- VARIABLE_ADDRESS_WIDTH, 11, literal address width
- NSAT, 3, literals per clause
- NUM_RD_PORTS, 2, independent read lanes (1–8)
- OUT_REG, 0, 1 adds an output pipeline register (read latency 1+OUT_REG)
- Derived: CT_WIDTH = (VARIABLE_ADDRESS_WIDTH+1)*(NSAT-1)*CLAUSE_COUNT; AW = $clog2(DEPTH)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  pulse: re-zero the whole table (honoured in LOAD only)
- run_i  in  1  level: 1 = solver running, table is read-only
- axi_wr_en_i  in  1  write strobe
- axi_wr_addr_i  in  AW  write row
- axi_wr_clauses_i  in  CT_WIDTH  write data
- axi_wr_ready_o  out  1  write accepted this cycle if strobed
- axi_wr_err_o  out  1  one-cycle pulse: strobe rejected
- rd_valid_i  in  NUM_RD_PORTS  per-lane read request
- rd_addr_i  in  NUM_RD_PORTS*AW  lane i at [i*AW +: AW]
- rd_ready_o  out  1  reads accepted (common to all lanes)
- clauses_o  out  NUM_RD_PORTS*CT_WIDTH  lane i at [i*CT_WIDTH +: CT_WIDTH]
- clauses_valid_o  out  NUM_RD_PORTS  per-lane data valid
- busy_o  out  1  clear sweep in progress

## Operation
- State machine: CLEAR, LOAD, RUN. Reset enters CLEAR with the sweep counter at 0.
- CLEAR:
  - Writes zero to row cnt in every bank each cycle and increments cnt.
  - After writing row DEPTH-1, goes to LOAD.
  - clear_i is ignored.
  - AXI strobes are rejected (axi_wr_err_o pulses).
  - rd_ready_o=0; rd_valid_i is ignored.
- LOAD:
  - axi_wr_ready_o=1; a strobe writes all banks.
  - clear_i → CLEAR with cnt=0. If clear_i and axi_wr_en_i coincide, clear wins and the write is rejected with err.
  - run_i=1 → RUN. A write in the same cycle is still accepted.
- RUN:
  - Strobes are rejected with err. clear_i is ignored.
  - run_i=0 → LOAD.
- Reads are accepted in LOAD and RUN: rd_ready_o=1, and each lane with rd_valid_i high is served independently.
- Collision: when a lane reads the same row that an accepted write targets in the same cycle, it returns the new data (write-first).
- Lanes without rd_valid_i keep their previous clauses_o value; valid is 0.
- Reset mid-operation: asynchronous return to CLEAR, outputs go to reset values, and memory contents are swept again.

## Timing
- Reset values:
  - clauses_o = 0
  - clauses_valid_o = 0
  - axi_wr_ready_o = 0
  - axi_wr_err_o = 0
  - busy_o = 1
- Read latency is 1+OUT_REG cycles. A request accepted at edge N gives data and valid at edge N+1+OUT_REG. Throughput is one read per lane per cycle.
- Requests accepted before a state change still complete.
- axi_wr_ready_o and rd_ready_o are registered from the state and are 0 in CLEAR.
- axi_wr_err_o asserts on the edge after the rejected strobe.
- Clear takes exactly DEPTH cycles. busy_o falls on the same edge LOAD is entered.
- The cnt register is AW bits wide. Sweep termination compares cnt == DEPTH-1; cnt never wraps into a second sweep.

## Structure
- Shared clause_table_pkg holds:
  - the CT_WIDTH and AW helper functions;
  - the state encoding (CLEAR=2'd0, LOAD=2'd1, RUN=2'd2);
  - the lane slice helpers.
- Sub-module clause_table_bank: one write port, one read port, synchronous-read RAM of DEPTH×CT_WIDTH. It is instantiated NUM_RD_PORTS times, with the write port shared.
- Top-level logic: FSM, sweep counter, write-mux between clear and AXI, per-lane forwarding compare, optional OUT_REG stage.

## Test plan
Parameters for all scenarios: DEPTH=16, CLAUSE_COUNT=2, NSAT=3, VARIABLE_ADDRESS_WIDTH=4, NUM_RD_PORTS=2.

1. Release reset → busy_o=1 for exactly 16 cycles, then rd_ready_o=1. Reads of rows 0 and 15 on both lanes return 0 with valid one cycle later.
2. In LOAD, write row 5=0xABCDE. Read row 5 on lane 0 and row 4 on lane 1 the next cycle → 0xABCDE and 0 together at latency 1. Repeat with OUT_REG=1 → latency 2.
3. Same-cycle write of row 7=0x12345 and lane-1 read of row 7 → lane 1 returns 0x12345.
4. Assert run_i, then strobe a write → axi_wr_err_o pulses once and row contents are unchanged. Drop run_i and write → accepted.
5. After populating rows, assert clear_i together with axi_wr_en_i → write rejected, busy_o high for 16 cycles, all rows read 0 afterwards.
6. Assert rst_ni low mid-sweep (cnt=8) → outputs go to reset values immediately. After release, the full 16-cycle sweep repeats.
